video_write_buffer: RTL and testbench
=====================================

Name: video_write_buffer

Overview:
- Sits directly downstream of the core's MEM-stage video interface (video_we/video_addr/video_data).
- Accepts every VRAM-range store in the cycle the core issues it. The core cannot be stalled, so this block has no ready signal back to it.
- Stores are buffered in a FIFO and drained to the framebuffer write port through a req/ack handshake.
- The block translates byte addresses to framebuffer word indices and drops and flags out-of-range or overflowing writes.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- VRAM_BASE, 32'h00008000, byte address of framebuffer word 0.
- FB_WORDS, 16384, number of framebuffer words; valid index range is 0..FB_WORDS-1.
- VRAM_ADDR_W, 14, width of vram_addr; must satisfy 2^VRAM_ADDR_W >= FB_WORDS.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- video_we  in  1  store strobe from core, one write per high cycle
- video_addr  in  32  store byte address
- video_data  in  32  store data
- vram_req  out  1  framebuffer write request
- vram_addr  out  VRAM_ADDR_W  framebuffer word index
- vram_data  out  32  framebuffer write data
- vram_ack  in  1  framebuffer accepted the current request this cycle
- clr_status  in  1  clears overflow, range_err and drop_count
- empty  out  1  FIFO holds 0 entries
- full  out  1  FIFO holds DEPTH entries
- level  out  $clog2(DEPTH)+1  current entry count
- overflow  out  1  sticky; a write was dropped because the FIFO was full
- range_err  out  1  sticky; a write was dropped because its address was out of range
- drop_count  out  16  total dropped writes, saturates at 16'hFFFF

Behaviour:
- Reset values: vram_req=0, vram_addr=0, vram_data=0, empty=1, full=0, level=0, overflow=0, range_err=0, drop_count=0. FIFO pointers are zeroed.
- Reset asserted mid-handshake abandons the request and all buffered entries. The consumer must ignore an ack that arrives in the cycle rst is high.
- Address decode is combinational on the input. idx = (video_addr - VRAM_BASE) >> 2, with the low 2 address bits ignored.
- A write is in range iff video_addr >= VRAM_BASE and idx < FB_WORDS.
- An out-of-range write with video_we=1 is not pushed. range_err is set and drop_count is incremented.
- Push condition: video_we & in-range & (!full | pop_this_cycle). A push and a pop in the same cycle at full is legal and level stays DEPTH.
- Push blocked when full with no pop: the write is dropped, overflow is set and drop_count is incremented.
- Drain FSM, two states:
  - IDLE: vram_req=0. Moves to REQ on the next edge when level becomes nonzero. Latency from a push into an empty FIFO to vram_req=1 is 1 cycle.
  - REQ: vram_req=1, with vram_addr/vram_data equal to the FIFO head. They are registered and stable until ack.
  - REQ with vram_ack=1: the head is popped the same cycle. If more entries remain, the FSM stays in REQ and presents the next head on the following cycle (back-to-back, 1 write/cycle maximum). Otherwise it returns to IDLE.
  - REQ with vram_ack=0: the FSM holds, with no change to addr or data.
- Ordering is strict FIFO. Writes reach VRAM in program order.
- level, empty and full are registered and reflect the post-edge count.
- drop_count increments by at most 1 per cycle, because only one input exists per cycle.
- clr_status clears the sticky flags and the counter. If a drop occurs in the same cycle as clr_status, the drop wins: flag=1, count=1.
- video_we=0 has no effect, regardless of the address.

Optional Feature:
- Macro: VWB_COALESCE_EN.
- Defined: an in-range write whose idx equals the most recently pushed entry's idx overwrites that entry's data instead of pushing. Condition: that entry is still in the FIFO and is not the head currently presented in REQ. A coalesced write never overflows and does not change level.
- Not defined: every accepted write occupies its own entry and no merging logic is generated.

Test Plan:
- Reset then single write: addr 0x8010, data 0xDEADBEEF, ack tied 1. Required: vram_req high 1 cycle later with vram_addr=4 and data=0xDEADBEEF, then empty=1.
- Ack held 0, then 9 writes with DEPTH=8. Required: full=1 after 8 writes; the 9th write sets overflow=1 and drop_count=1. After releasing ack, exactly 8 writes drain in order.
- Range checks: writes to 0x7FFC and to VRAM_BASE+4*FB_WORDS. Required: range_err=1, drop_count=2, vram_req never asserted. Then clr_status -> all three cleared.
- Full FIFO, ack=1, and a new write in the same cycle. Required: accepted, level stays 8, overflow=0.
- Burst of 5 writes with ack alternating 1/0. Required: vram_addr/vram_data stable while ack=0, and output order matches input order.
- With VWB_COALESCE_EN: ack=0, write idx 3 data 1 then idx 5 data 2, then idx 5 data 3. Required: level=2, and the drain produces (3,1),(5,3). Without the macro: level=3.

Source files
------------

// File: rtl/video_write_buffer.sv
// Write buffer between the core's video store port and the framebuffer write port.
// Optional store coalescing is enabled by defining VWB_COALESCE_EN.
module video_write_buffer #(
  parameter int          DEPTH       = 8,
  parameter logic [31:0] VRAM_BASE   = 32'h0000_8000,
  parameter int          FB_WORDS    = 16384,
  parameter int          VRAM_ADDR_W = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       video_we,
  input  logic [31:0]                video_addr,
  input  logic [31:0]                video_data,
  output logic                       vram_req,
  output logic [VRAM_ADDR_W-1:0]     vram_addr,
  output logic [31:0]                vram_data,
  input  logic                       vram_ack,
  input  logic                       clr_status,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       range_err,
  output logic [15:0]                drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t                   state_q, state_d;
  logic [VRAM_ADDR_W-1:0]   mem_addr [DEPTH];
  logic [31:0]              mem_data [DEPTH];
  logic [PTR_W-1:0]         rd_ptr, wr_ptr, rd_next, wr_last;
  logic [LVL_W-1:0]         level_nxt;
  logic [31:0]              idx_w;
  logic [VRAM_ADDR_W-1:0]   idx;
  logic                     in_range, coal, push, pop, drop_ovf, drop_rng;
  logic                     load_head, head_from_mem, fwd;
  logic [VRAM_ADDR_W-1:0]   head_addr_d;
  logic [31:0]              head_data_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign idx_w    = (video_addr - VRAM_BASE) >> 2;
  assign idx      = idx_w[VRAM_ADDR_W-1:0];
  assign in_range = (video_addr >= VRAM_BASE) && (idx_w < 32'(FB_WORDS));
  assign rd_next  = PTR_W'(rd_ptr + 1'b1);
  assign wr_last  = PTR_W'(wr_ptr - 1'b1);

`ifdef VWB_COALESCE_EN
  logic [VRAM_ADDR_W-1:0] last_idx;
  // With two or more entries the most recent one can never be the presented head.
  assign coal = video_we && in_range && (level >= LVL_W'(2)) && (idx == last_idx);
  assign fwd  = coal && (level == LVL_W'(2));

  always_ff @(posedge clk) begin
    if (push) last_idx <= idx;
  end
`else
  assign coal = 1'b0;
  assign fwd  = 1'b0;
`endif

  assign pop       = (state_q == REQ) && vram_ack;
  assign push      = video_we && in_range && !coal && (!full || pop);
  assign drop_ovf  = video_we && in_range && !coal && full && !pop;
  assign drop_rng  = video_we && !in_range;
  assign level_nxt = level + LVL_W'(push) - LVL_W'(pop);
  assign vram_req  = (state_q == REQ);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    load_head     = 1'b0;
    head_from_mem = (state_q == REQ) && (level >= LVL_W'(2));
    head_addr_d   = head_from_mem ? mem_addr[rd_next] : idx;
    head_data_d   = video_data;
    if (head_from_mem && !fwd) head_data_d = mem_data[rd_next];
    case (state_q)
      IDLE: begin
        if (push) begin
          state_d   = REQ;
          load_head = 1'b1;
        end
      end
      REQ: begin
        if (pop) begin
          if (level_nxt != '0) load_head = 1'b1;
          else                 state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry storage carries no reset; pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= idx;
      mem_data[wr_ptr] <= video_data;
    end
    if (coal) mem_data[wr_last] <= video_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      vram_addr <= '0;
      vram_data <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= rd_next;
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == LVL_W'(DEPTH));
      if (load_head) begin
        vram_addr <= head_addr_d;
        vram_data <= head_data_d;
      end
    end
  end

  // A drop coinciding with clr_status leaves the fresh drop recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      range_err  <= 1'b0;
      drop_count <= '0;
    end else if (clr_status) begin
      overflow   <= drop_ovf;
      range_err  <= drop_rng;
      drop_count <= {15'd0, drop_ovf | drop_rng};
    end else begin
      overflow  <= overflow | drop_ovf;
      range_err <= range_err | drop_rng;
      if (drop_ovf || drop_rng) drop_count <= sat_inc(drop_count);
    end
  end

endmodule

// File: tb/tb_video_write_buffer.sv
// Bench for video_write_buffer: directed scenarios plus random traffic against a queue model.
module tb_video_write_buffer;
  localparam int          DEPTH    = 8;
  localparam logic [31:0] BASE     = 32'h0000_8000;
  localparam int          FB_WORDS = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        video_we = 1'b0;
  logic [31:0] video_addr = '0;
  logic [31:0] video_data = '0;
  logic        vram_req;
  logic [13:0] vram_addr;
  logic [31:0] vram_data;
  logic        vram_ack = 1'b0;
  logic        clr_status = 1'b0;
  logic        empty, full, overflow, range_err;
  logic [3:0]  level;
  logic [15:0] drop_count;

  video_write_buffer #(
    .DEPTH(DEPTH), .VRAM_BASE(BASE), .FB_WORDS(FB_WORDS), .VRAM_ADDR_W(14)
  ) dut (
    .clk(clk), .rst(rst), .video_we(video_we), .video_addr(video_addr),
    .video_data(video_data), .vram_req(vram_req), .vram_addr(vram_addr),
    .vram_data(vram_data), .vram_ack(vram_ack), .clr_status(clr_status),
    .empty(empty), .full(full), .level(level), .overflow(overflow),
    .range_err(range_err), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] idx;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_ovf = 1'b0;
  logic        m_rerr = 1'b0;
  int          m_dc = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 2) < 32'(FB_WORDS));
  endfunction

  task automatic compare_all();
    chk("vram_req", 32'(vram_req), 32'(q.size() > 0));
    chk("level", 32'(level), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("range_err", 32'(range_err), 32'(m_rerr));
    chk("drop_count", 32'(drop_count), 32'(m_dc));
    if (q.size() > 0) begin
      chk("vram_addr", 32'(vram_addr), 32'(q[0].idx));
      chk("vram_data", vram_data, q[0].data);
    end
  endtask

  // One clock: drive inputs, advance the model by the behavioural rules, then compare.
  task automatic cycle(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic ack, input logic clr);
    bit   pop, coal, dro, drr, push, ok;
    ent_t e, t;
    video_we = we; video_addr = addr; video_data = data;
    vram_ack = ack; clr_status = clr;
    ok   = in_rng(addr);
    pop  = (q.size() > 0) && ack;
    e.idx  = 14'((addr - BASE) >> 2);
    e.data = data;
    coal = 1'b0;
`ifdef VWB_COALESCE_EN
    if (we && ok && q.size() >= 2 && q[q.size()-1].idx == e.idx) coal = 1'b1;
`endif
    drr  = we && !ok;
    dro  = we && ok && !coal && (q.size() == DEPTH) && !pop;
    push = we && ok && !coal && !dro;
    if (coal) begin
      t = q[q.size()-1];
      t.data = data;
      q[q.size()-1] = t;
    end
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(e);
    if (clr) begin
      m_ovf  = dro;
      m_rerr = drr;
      m_dc   = (dro || drr) ? 1 : 0;
    end else begin
      m_ovf  = m_ovf | dro;
      m_rerr = m_rerr | drr;
      if ((dro || drr) && m_dc < 16'hFFFF) m_dc++;
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] a, last_a;
    logic        ack;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(vram_req), 32'd0);
    chk("rst_addr", 32'(vram_addr), 32'd0);
    chk("rst_data", vram_data, 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_flags", {30'd0, overflow, range_err}, 32'd0);
    chk("rst_dc", 32'(drop_count), 32'd0);
    rst = 1'b0;

    // Single write with ack held high
    cycle(1'b1, 32'h0000_8010, 32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("single_req", 32'(vram_req), 32'd1);
    chk("single_addr", 32'(vram_addr), 32'd4);
    chk("single_data", vram_data, 32'hDEAD_BEEF);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("single_empty", 32'(empty), 32'd1);

    // Overflow with ack held low
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, BASE + 32'(4 * (i + 20)), $urandom, 1'b0, 1'b0);
      if (i == 7) chk("ovf_full8", 32'(full), 32'd1);
    end
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_dc", 32'(drop_count), 32'd1);
    drain(8);
    chk("ovf_drained", 32'(empty), 32'd1);

    // Out-of-range writes, then clear
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h0000_7FFC, 32'h1111_1111, 1'b1, 1'b0);
    cycle(1'b1, BASE + 32'(4 * FB_WORDS), 32'h2222_2222, 1'b1, 1'b0);
    chk("rng_flag", 32'(range_err), 32'd1);
    chk("rng_dc", 32'(drop_count), 32'd2);
    chk("rng_noreq", 32'(vram_req), 32'd0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("clr_all", {15'd0, overflow, range_err, drop_count}, 32'd0);

    // Push and pop together at full
    for (int i = 0; i < 8; i++) cycle(1'b1, BASE + 32'(4 * i), $urandom, 1'b0, 1'b0);
    cycle(1'b1, BASE + 32'h40, 32'hCAFE_F00D, 1'b1, 1'b0);
    chk("pp_level", 32'(level), 32'd8);
    chk("pp_ovf", 32'(overflow), 32'd0);
    drain(8);

    // Burst of 5 with alternating ack
    for (int i = 0; i < 5; i++) cycle(1'b1, BASE + 32'(4 * (100 + i)), $urandom, 1'(i % 2 == 0), 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 32'h0, 1'(i % 2 == 0), 1'b0);
    chk("burst_empty", 32'(empty), 32'd1);

    // Same-index writes while ack is low
    cycle(1'b1, BASE + 32'd12, 32'd1, 1'b0, 1'b0);
    cycle(1'b1, BASE + 32'd20, 32'd2, 1'b0, 1'b0);
    cycle(1'b1, BASE + 32'd20, 32'd3, 1'b0, 1'b0);
`ifdef VWB_COALESCE_EN
    chk("coal_level", 32'(level), 32'd2);
`else
    chk("coal_level", 32'(level), 32'd3);
`endif
    drain(4);

    // Random traffic
    last_a = BASE;
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 32'h7FFF))
                                                      : BASE + 32'(4 * FB_WORDS) + 32'($urandom_range(0, 255));
      else if (r < 4)  a = last_a;
      else             a = BASE + 32'(4 * $urandom_range(0, FB_WORDS - 1)) + 32'($urandom_range(0, 3));
      if (in_rng(a)) last_a = a;
      ack = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle(1'($urandom_range(0, 3) != 0), a, $urandom, ack, 1'($urandom_range(0, 40) == 0));
    end
    drain(DEPTH + 1);
    chk("final_empty", 32'(empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
